// File: rtl/rdma_rd_rsp_engine.sv
// rtl/rdma_rd_rsp_engine.sv - RDMA read-request responder: memory command issue and response re-framing
//
// Purpose:
//   Accepts read-request descriptors from the network stack, issues one
//   local-memory read command per descriptor and passes the returned memory
//   data through as the rd_rsp stream with tkeep/tlast framed from the
//   request length. One request is in flight at a time, strictly in order.
//   Zero-length descriptors are dropped and counted.
//
// Ports:
//   aclk, aresetn                          clock, asynchronous active-low reset
//   s_rd_req_valid/ready/data              descriptor in: [63:0] vaddr, [95:64] len, [127:96] ignored
//   m_mem_cmd_valid/ready/data             memory read command out: [63:0] vaddr, [95:64] len
//   s_axis_mem_tvalid/tready/tdata         memory return data in
//   m_axis_rd_rsp_tvalid/tready/tdata/
//   tkeep/tlast                            response stream out
//   zero_len_drops                         saturating count of len==0 descriptors
//   stat_reqs, stat_bytes                  completed requests / bytes
//
// Optional feature macro: RDMA_RSP_STATS_EN
//   Defined   : stat_reqs/stat_bytes count completed requests and bytes (wrapping).
//   Undefined : stat_reqs/stat_bytes are tied to zero.

module rdma_rd_rsp_engine #(
  parameter int DATA_BITS = 512,
  parameter int REQ_BITS  = 128,
  parameter int LEN_BITS  = 32
) (
  input  logic                     aclk,
  input  logic                     aresetn,

  input  logic                     s_rd_req_valid,
  output logic                     s_rd_req_ready,
  input  logic [REQ_BITS-1:0]      s_rd_req_data,

  output logic                     m_mem_cmd_valid,
  input  logic                     m_mem_cmd_ready,
  output logic [64+LEN_BITS-1:0]   m_mem_cmd_data,

  input  logic                     s_axis_mem_tvalid,
  output logic                     s_axis_mem_tready,
  input  logic [DATA_BITS-1:0]     s_axis_mem_tdata,

  output logic                     m_axis_rd_rsp_tvalid,
  input  logic                     m_axis_rd_rsp_tready,
  output logic [DATA_BITS-1:0]     m_axis_rd_rsp_tdata,
  output logic [DATA_BITS/8-1:0]   m_axis_rd_rsp_tkeep,
  output logic                     m_axis_rd_rsp_tlast,

  output logic [31:0]              zero_len_drops,
  output logic [31:0]              stat_reqs,
  output logic [63:0]              stat_bytes
);

  localparam int BPB      = DATA_BITS / 8;
  localparam int OFF_BITS = $clog2(BPB);
  // ceil(len/BPB) for the largest len needs one bit more than len[LEN_BITS-1:OFF_BITS]
  localparam int CNT_BITS = LEN_BITS - OFF_BITS + 1;
  localparam int LB_BITS  = OFF_BITS + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA
  } state_t;

  state_t                state_q;
  logic                  req_ready_q;
  logic                  cmd_valid_q;
  logic [63:0]           vaddr_q;
  logic [LEN_BITS-1:0]   len_q;
  logic [CNT_BITS-1:0]   beats_total_q;
  logic [LB_BITS-1:0]    last_bytes_q;
  logic [CNT_BITS-1:0]   beat_cnt_q;
  logic [31:0]           zero_len_drops_q;

  // Descriptor fields
  logic [63:0]           req_vaddr;
  logic [LEN_BITS-1:0]   req_len;
  logic                  unused_rsvd;
  logic [CNT_BITS-1:0]   beats_total_d;
  logic [LB_BITS-1:0]    last_bytes_d;

  assign req_vaddr   = s_rd_req_data[63:0];
  assign req_len     = s_rd_req_data[64 +: LEN_BITS];
  assign unused_rsvd = ^s_rd_req_data[REQ_BITS-1:64+LEN_BITS];

  assign beats_total_d = CNT_BITS'(req_len[LEN_BITS-1:OFF_BITS])
                       + CNT_BITS'(|req_len[OFF_BITS-1:0]);
  assign last_bytes_d  = (req_len[OFF_BITS-1:0] == '0) ? LB_BITS'(BPB)
                                                       : {1'b0, req_len[OFF_BITS-1:0]};

  // Data phase is a combinational pass-through gated by the state
  logic                  in_data;
  logic                  tlast_w;
  logic                  rsp_hs;
  logic [LB_BITS-1:0]    keep_shift;
  logic [BPB-1:0]        keep_last;

  assign in_data    = (state_q == ST_DATA);
  assign tlast_w    = (beat_cnt_q == beats_total_q - CNT_BITS'(1));
  assign keep_shift = LB_BITS'(BPB) - last_bytes_q;
  assign keep_last  = {BPB{1'b1}} >> keep_shift;

  assign m_axis_rd_rsp_tvalid = in_data & s_axis_mem_tvalid;
  assign s_axis_mem_tready    = in_data & m_axis_rd_rsp_tready;
  assign m_axis_rd_rsp_tdata  = s_axis_mem_tdata;
  assign m_axis_rd_rsp_tlast  = in_data & tlast_w;
  assign m_axis_rd_rsp_tkeep  = tlast_w ? keep_last : {BPB{1'b1}};
  assign rsp_hs               = m_axis_rd_rsp_tvalid & m_axis_rd_rsp_tready;

  assign s_rd_req_ready  = req_ready_q;
  assign m_mem_cmd_valid = cmd_valid_q;
  assign m_mem_cmd_data  = {len_q, vaddr_q};
  assign zero_len_drops  = zero_len_drops_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q          <= ST_IDLE;
      req_ready_q      <= 1'b1;
      cmd_valid_q      <= 1'b0;
      vaddr_q          <= '0;
      len_q            <= '0;
      beats_total_q    <= '0;
      last_bytes_q     <= '0;
      beat_cnt_q       <= '0;
      zero_len_drops_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (s_rd_req_valid && req_ready_q) begin
            if (req_len != '0) begin
              vaddr_q       <= req_vaddr;
              len_q         <= req_len;
              beats_total_q <= beats_total_d;
              last_bytes_q  <= last_bytes_d;
              req_ready_q   <= 1'b0;
              cmd_valid_q   <= 1'b1;
              state_q       <= ST_CMD;
            end else if (zero_len_drops_q != '1) begin
              zero_len_drops_q <= zero_len_drops_q + 32'd1;
            end
          end
        end
        ST_CMD: begin
          if (m_mem_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            beat_cnt_q  <= '0;
            state_q     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (rsp_hs) begin
            if (tlast_w) begin
              req_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_BITS'(1);
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          cmd_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef RDMA_RSP_STATS_EN
  logic [31:0] stat_reqs_q;
  logic [63:0] stat_bytes_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_reqs_q  <= '0;
      stat_bytes_q <= '0;
    end else if (rsp_hs && tlast_w) begin
      stat_reqs_q  <= stat_reqs_q + 32'd1;
      stat_bytes_q <= stat_bytes_q + 64'(len_q);
    end
  end

  assign stat_reqs  = stat_reqs_q;
  assign stat_bytes = stat_bytes_q;
`else
  assign stat_reqs  = '0;
  assign stat_bytes = '0;
`endif

endmodule
